// File: rtl/cordic_ln_control_unit.sv
// Moore control unit for the floating-point CORDIC ln(T) coprocessor.
// Sequences T+1 / T-1 setup, ITERS hyperbolic vectoring micro-rotations with
// the repeated shifts at 4 and 13, and the final Z doubling. Holds no data.
module cordic_ln_control_unit #(
    parameter int unsigned ITERS = 16,
    parameter int unsigned D     = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Begin_FSM,
    input  logic         ACK_SUM,
    input  logic         DIR,
    output logic         MS_1,
    output logic [1:0]   MS_2,
    output logic         MS_3,
    output logic [1:0]   MS_4,
    output logic         ADD_SUBT,
    output logic         Begin_SUM,
    output logic         EN_REG3,
    output logic         EN_REG1X,
    output logic         EN_REG1Y,
    output logic         EN_REG1Z,
    output logic         EN_REG2,
    output logic         EN_REG2XYZ,
    output logic         EN_REG4,
    output logic         CLK_CDIR,
    output logic         CLR_Z,
    output logic [D-1:0] SHIFT_AMT,
    output logic         BUSY,
    output logic         READY
);

    localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    // Each adder macro-op is a Start / Wait / Store triple.
    typedef enum logic [4:0] {
        StIdle, StLoad,
        StInitXStart, StInitXWait, StInitXStore,
        StInitYStart, StInitYWait, StInitYStore,
        StClr, StCommit, StRotDir,
        StXStart, StXWait, StXStore,
        StYStart, StYWait, StYStore,
        StZStart, StZWait, StZStore,
        StIterCommit,
        StFinStart, StFinWait, StFinStore,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [D-1:0]  shift_q, shift_d;
    logic          rep_q, rep_d;

    logic          ms_1_d, ms_3_d, begin_sum_d, busy_d, ready_d;
    logic [1:0]    ms_2_d, ms_4_d;
    logic          en_reg3_d, en_reg1x_d, en_reg1y_d, en_reg1z_d;
    logic          en_reg2_d, en_reg2xyz_d, en_reg4_d, clk_cdir_d, clr_z_d;
    logic [D-1:0]  shift_amt_d;
    logic          as_fix_d, as_fix_q, as_dir_d, as_dir_q, as_inv_d, as_inv_q;

    // Next-state, step counter and shift-sequence logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rep_d   = rep_q;
        unique case (state_q)
            StIdle:       if (Begin_FSM) state_d = StLoad;
            StLoad:       state_d = StInitXStart;
            StInitXStart: state_d = StInitXWait;
            StInitXWait:  if (ACK_SUM) state_d = StInitXStore;
            StInitXStore: state_d = StInitYStart;
            StInitYStart: state_d = StInitYWait;
            StInitYWait:  if (ACK_SUM) state_d = StInitYStore;
            StInitYStore: state_d = StClr;
            StClr:        state_d = StCommit;
            StCommit: begin
                state_d = StRotDir;
                cnt_d   = '0;
                shift_d = D'(1);
                rep_d   = 1'b0;
            end
            StRotDir:     state_d = StXStart;
            StXStart:     state_d = StXWait;
            StXWait:      if (ACK_SUM) state_d = StXStore;
            StXStore:     state_d = StYStart;
            StYStart:     state_d = StYWait;
            StYWait:      if (ACK_SUM) state_d = StYStore;
            StYStore:     state_d = StZStart;
            StZStart:     state_d = StZWait;
            StZWait:      if (ACK_SUM) state_d = StZStore;
            StZStore:     state_d = StIterCommit;
            StIterCommit: begin
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d = StFinStart;
                end else begin
                    state_d = StRotDir;
                    cnt_d   = cnt_q + CW'(1);
                end
                // Shifts 4 and 13 are each used twice for hyperbolic convergence.
                if (!rep_q && (shift_q == D'(4) || shift_q == D'(13))) begin
                    rep_d = 1'b1;
                end else begin
                    shift_d = shift_q + D'(1);
                    rep_d   = 1'b0;
                end
            end
            StFinStart:   state_d = StFinWait;
            StFinWait:    if (ACK_SUM) state_d = StFinStore;
            StFinStore:   state_d = StDone;
            StDone:       state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    // Output decode from the next state so every output leaves a register.
    always_comb begin
        ms_1_d       = 1'b0;
        ms_2_d       = 2'b00;
        ms_3_d       = 1'b0;
        ms_4_d       = 2'b00;
        as_fix_d     = 1'b0;
        as_dir_d     = 1'b0;
        as_inv_d     = 1'b0;
        begin_sum_d  = 1'b0;
        en_reg3_d    = 1'b0;
        en_reg1x_d   = 1'b0;
        en_reg1y_d   = 1'b0;
        en_reg1z_d   = 1'b0;
        en_reg2_d    = 1'b0;
        en_reg2xyz_d = 1'b0;
        en_reg4_d    = 1'b0;
        clk_cdir_d   = 1'b0;
        clr_z_d      = 1'b0;
        ready_d      = 1'b0;
        shift_amt_d  = '0;
        busy_d       = (state_d != StIdle) && (state_d != StDone);
        unique case (state_d)
            StLoad: en_reg3_d = 1'b1;
            StInitXStart, StInitXWait, StInitXStore: begin
                ms_1_d = 1'b1;
                ms_4_d = 2'b10;
            end
            StInitYStart, StInitYWait, StInitYStore: begin
                ms_1_d   = 1'b1;
                ms_4_d   = 2'b10;
                as_fix_d = 1'b1;
            end
            StClr: clr_z_d = 1'b1;
            StCommit: en_reg2xyz_d = 1'b1;
            StRotDir: begin
                en_reg2_d   = 1'b1;
                clk_cdir_d  = 1'b1;
                shift_amt_d = shift_d;
            end
            StXStart, StXWait, StXStore: begin
                ms_4_d      = 2'b01;
                as_dir_d    = 1'b1;
                as_inv_d    = 1'b1;
                shift_amt_d = shift_d;
            end
            StYStart, StYWait, StYStore: begin
                ms_2_d      = 2'b01;
                ms_3_d      = 1'b1;
                ms_4_d      = 2'b01;
                as_dir_d    = 1'b1;
                as_inv_d    = 1'b1;
                shift_amt_d = shift_d;
            end
            StZStart, StZWait, StZStore: begin
                ms_2_d      = 2'b10;
                as_dir_d    = 1'b1;
                shift_amt_d = shift_d;
            end
            StIterCommit: begin
                en_reg2xyz_d = 1'b1;
                shift_amt_d  = shift_d;
            end
            StFinStart, StFinWait, StFinStore: begin
                ms_2_d = 2'b10;
                ms_4_d = 2'b11;
            end
            StDone: ready_d = 1'b1;
            default: ;
        endcase
        unique case (state_d)
            StInitXStart, StInitYStart, StXStart,
            StYStart, StZStart, StFinStart:  begin_sum_d = 1'b1;
            StInitXStore, StXStore:          en_reg1x_d  = 1'b1;
            StInitYStore, StYStore:          en_reg1y_d  = 1'b1;
            StZStore:                        en_reg1z_d  = 1'b1;
            StFinStore:                      en_reg4_d   = 1'b1;
            default: ;
        endcase
    end

    // State and registered outputs; async reset clears everything at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            rep_q      <= 1'b0;
            MS_1       <= 1'b0;
            MS_2       <= 2'b00;
            MS_3       <= 1'b0;
            MS_4       <= 2'b00;
            as_fix_q   <= 1'b0;
            as_dir_q   <= 1'b0;
            as_inv_q   <= 1'b0;
            Begin_SUM  <= 1'b0;
            EN_REG3    <= 1'b0;
            EN_REG1X   <= 1'b0;
            EN_REG1Y   <= 1'b0;
            EN_REG1Z   <= 1'b0;
            EN_REG2    <= 1'b0;
            EN_REG2XYZ <= 1'b0;
            EN_REG4    <= 1'b0;
            CLK_CDIR   <= 1'b0;
            CLR_Z      <= 1'b0;
            SHIFT_AMT  <= '0;
            BUSY       <= 1'b0;
            READY      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rep_q      <= rep_d;
            MS_1       <= ms_1_d;
            MS_2       <= ms_2_d;
            MS_3       <= ms_3_d;
            MS_4       <= ms_4_d;
            as_fix_q   <= as_fix_d;
            as_dir_q   <= as_dir_d;
            as_inv_q   <= as_inv_d;
            Begin_SUM  <= begin_sum_d;
            EN_REG3    <= en_reg3_d;
            EN_REG1X   <= en_reg1x_d;
            EN_REG1Y   <= en_reg1y_d;
            EN_REG1Z   <= en_reg1z_d;
            EN_REG2    <= en_reg2_d;
            EN_REG2XYZ <= en_reg2xyz_d;
            EN_REG4    <= en_reg4_d;
            CLK_CDIR   <= clk_cdir_d;
            CLR_Z      <= clr_z_d;
            SHIFT_AMT  <= shift_amt_d;
            BUSY       <= busy_d;
            READY      <= ready_d;
        end
    end

    // DIR only settles on the edge that leaves ROT_DIR, so the rotation ops
    // take it live instead of through the output register.
    assign ADD_SUBT = as_dir_q ? (DIR ^ as_inv_q) : as_fix_q;

endmodule

// File: tb/tb_cordic_ln_control_unit.sv
// Scoreboard bench for cordic_ln_control_unit: stimulus pushes expected adder
// ops, shift amounts and run latencies; a monitor pops and compares them.
module tb_cordic_ln_control_unit;

    localparam int unsigned ITERS   = 16;
    localparam int unsigned D       = 5;
    localparam int          ADD_LAT = 4;
    localparam int          RUN_CYC = 342;
    localparam int          NUM_OPS = 51;

    logic         CLK = 1'b0;
    logic         RST, Begin_FSM, ACK_SUM, DIR;
    logic         MS_1, MS_3, ADD_SUBT, Begin_SUM, BUSY, READY;
    logic [1:0]   MS_2, MS_4;
    logic         EN_REG3, EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG4;
    logic         CLK_CDIR, CLR_Z;
    logic [D-1:0] SHIFT_AMT;

    always #5 CLK = ~CLK;

    cordic_ln_control_unit #(.ITERS(ITERS), .D(D)) dut (
        .CLK(CLK), .RST(RST), .Begin_FSM(Begin_FSM), .ACK_SUM(ACK_SUM), .DIR(DIR),
        .MS_1(MS_1), .MS_2(MS_2), .MS_3(MS_3), .MS_4(MS_4), .ADD_SUBT(ADD_SUBT),
        .Begin_SUM(Begin_SUM), .EN_REG3(EN_REG3), .EN_REG1X(EN_REG1X),
        .EN_REG1Y(EN_REG1Y), .EN_REG1Z(EN_REG1Z), .EN_REG2(EN_REG2),
        .EN_REG2XYZ(EN_REG2XYZ), .EN_REG4(EN_REG4), .CLK_CDIR(CLK_CDIR),
        .CLR_Z(CLR_Z), .SHIFT_AMT(SHIFT_AMT), .BUSY(BUSY), .READY(READY)
    );

    logic [23:0] outs;
    logic [11:0] cur_sel;
    logic [3:0]  stores;
    assign outs = {MS_1, MS_2, MS_3, MS_4, ADD_SUBT, Begin_SUM, EN_REG3, EN_REG1X,
                   EN_REG1Y, EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG4, CLK_CDIR, CLR_Z,
                   SHIFT_AMT, BUSY, READY};
    assign cur_sel = {MS_1, MS_2, MS_3, MS_4, ADD_SUBT, SHIFT_AMT};
    assign stores  = {EN_REG4, EN_REG1Z, EN_REG1Y, EN_REG1X};

    typedef struct packed {
        logic [3:0]  dest;
        logic [11:0] mask;
        logic [11:0] sel;
    } op_t;

    op_t op_q[$];
    int  shift_q[$];
    int  lat_q[$];
    int  shift_tab[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  dir_mode = 0;
    bit  stall_once = 0;
    int  add_cnt;
    int  iter_idx;
    bit  run_active = 0;
    bit  pend = 0;
    bit  prev_bsum = 0;
    logic [11:0] pend_sel;
    logic [3:0]  pend_dest;
    int  load_cyc = 0;
    int  ready_cyc = 0;
    int  bsum_cnt = 0;
    int  cdir_cnt = 0;
    op_t e;
    int  exp_sh, exp_lat;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic m1, input logic [1:0] m2, input logic m3,
                                       input logic [1:0] m4, input logic as, input int sh);
        return {m1, m2, m3, m4, as, 5'(sh)};
    endfunction

    function automatic op_t mkop(input logic [3:0] dest, input logic [11:0] mask,
                                 input logic [11:0] sel);
        op_t o;
        o.dest = dest;
        o.mask = mask;
        o.sel  = sel;
        return o;
    endfunction

    // Adder model: ACK_SUM rises after ADD_LAT wait cycles (plus 50 when stalled).
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ACK_SUM <= 1'b0;
            add_cnt <= 0;
        end else if (Begin_SUM) begin
            ACK_SUM <= 1'b0;
            add_cnt <= (stall_once ? ADD_LAT + 50 : ADD_LAT) - 1;
        end else if (add_cnt > 0) begin
            add_cnt <= add_cnt - 1;
            if (add_cnt == 1) ACK_SUM <= 1'b1;
        end
    end

    // Direction flip-flop model: preset opposite to the first captured value.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            DIR      <= 1'b0;
            iter_idx <= 0;
        end else if (EN_REG3) begin
            DIR      <= (dir_mode == 1);
            iter_idx <= 0;
        end else if (CLK_CDIR) begin
            DIR      <= (dir_mode == 1) ? iter_idx[0] : 1'b0;
            iter_idx <= iter_idx + 1;
        end
    end

    task automatic push_run(input int dmode, input int lat);
        logic d;
        op_q.push_back(mkop(4'b0001, 12'h8FF, mk(1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 0)));
        op_q.push_back(mkop(4'b0010, 12'h8FF, mk(1'b1, 2'b00, 1'b0, 2'b10, 1'b1, 0)));
        for (int k = 0; k < int'(ITERS); k++) begin
            d = (dmode == 1) ? k[0] : 1'b0;
            op_q.push_back(mkop(4'b0001, 12'hFFF,
                                mk(1'b0, 2'b00, 1'b0, 2'b01, ~d, shift_tab[k])));
            op_q.push_back(mkop(4'b0010, 12'hFFF,
                                mk(1'b0, 2'b01, 1'b1, 2'b01, ~d, shift_tab[k])));
            op_q.push_back(mkop(4'b0100, 12'hEFF,
                                mk(1'b0, 2'b10, 1'b0, 2'b00, d, shift_tab[k])));
            shift_q.push_back(shift_tab[k]);
        end
        op_q.push_back(mkop(4'b1000, 12'h6FF, mk(1'b0, 2'b10, 1'b0, 2'b11, 1'b0, 0)));
        lat_q.push_back(lat);
    endtask

    task automatic flush();
        op_q.delete();
        shift_q.delete();
        lat_q.delete();
        run_active = 0;
        pend       = 0;
        prev_bsum  = 0;
    endtask

    task automatic start_run();
        @(negedge CLK);
        Begin_FSM = 1'b1;
        @(negedge CLK);
        Begin_FSM = 1'b0;
        #1;
        chk(EN_REG3 == 1'b1, "load_after_start", EN_REG3, 1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((lat_q.size() != 0 || run_active) && n < budget) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= budget) begin
            chk(1'b0, name, n, budget);
            flush();
        end
    endtask

    task automatic check_run_end(input string name);
        chk(bsum_cnt == NUM_OPS, name, bsum_cnt, NUM_OPS);
        chk(op_q.size() == 0 && shift_q.size() == 0, "queues_drained", op_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows an event.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_bsum = 0;
                continue;
            end
            if (EN_REG3) begin
                chk(!run_active, "load_while_busy", 1, 0);
                run_active = 1;
                load_cyc   = cyc;
                bsum_cnt   = 0;
                cdir_cnt   = 0;
            end
            if (Begin_SUM) begin
                chk(!prev_bsum, "bsum_back_to_back", 1, 0);
                bsum_cnt++;
                if (op_q.size() == 0) begin
                    chk(1'b0, "bsum_unexpected", bsum_cnt, 0);
                end else begin
                    e = op_q.pop_front();
                    chk((cur_sel & e.mask) == (e.sel & e.mask), "op_selects",
                        int'(cur_sel), int'(e.sel));
                    pend      = 1;
                    pend_sel  = cur_sel;
                    pend_dest = e.dest;
                end
            end else if (pend) begin
                chk(cur_sel == pend_sel, "sel_hold", int'(cur_sel), int'(pend_sel));
            end
            if (stores != 4'b0000) begin
                chk(pend && stores == pend_dest, "store_dest", int'(stores), int'(pend_dest));
                pend = 0;
            end
            if (CLK_CDIR) begin
                cdir_cnt++;
                if (shift_q.size() == 0) begin
                    chk(1'b0, "rot_unexpected", cdir_cnt, 0);
                end else begin
                    exp_sh = shift_q.pop_front();
                    chk(int'(SHIFT_AMT) == exp_sh, "shift_amt", int'(SHIFT_AMT), exp_sh);
                end
            end
            if (READY) begin
                if (lat_q.size() == 0) begin
                    chk(1'b0, "ready_unexpected", cyc, 0);
                end else begin
                    exp_lat = lat_q.pop_front();
                    chk(cyc - load_cyc + 1 == exp_lat, "latency", cyc - load_cyc + 1, exp_lat);
                end
                run_active = 0;
                ready_cyc  = cyc;
            end
            chk(BUSY == run_active, "busy", BUSY, run_active);
            prev_bsum = Begin_SUM;
        end
    end

    initial begin
        int n;
        RST       = 1'b0;
        Begin_FSM = 1'b0;
        #2 RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            Begin_FSM = 1'($urandom_range(0, 1));
            #1;
            chk(outs == 24'd0, "reset_outputs", int'(outs), 0);
        end
        Begin_FSM = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk(outs == 24'd0, "idle_after_reset", int'(outs), 0);

        // DIR tied 0: X/Y ops subtract, Z ops add.
        dir_mode = 0;
        push_run(0, RUN_CYC);
        start_run();
        wait_done(1000, "run_dir0_timeout");
        check_run_end("bsum_count_dir0");

        // DIR toggling every iteration.
        dir_mode = 1;
        push_run(1, RUN_CYC);
        start_run();
        wait_done(1000, "run_toggle_timeout");
        check_run_end("bsum_count_toggle");

        // Begin_FSM held high through a whole run and its DONE.
        dir_mode = 0;
        push_run(0, RUN_CYC);
        push_run(0, RUN_CYC);
        @(negedge CLK);
        Begin_FSM = 1'b1;
        n = 0;
        while (!(lat_q.size() < 2 && run_active) && n < 1000) begin
            @(negedge CLK);
            #1;
            n++;
        end
        Begin_FSM = 1'b0;
        chk(n < 1000, "held_restart_timeout", n, 1000);
        chk(load_cyc - ready_cyc == 2, "restart_gap", load_cyc - ready_cyc, 2);
        wait_done(1000, "run_held_timeout");
        check_run_end("bsum_count_held");

        // Abort during the 5th iteration's X-op WAIT.
        dir_mode = 1;
        push_run(1, RUN_CYC);
        start_run();
        n = 0;
        while (cdir_cnt < 5 && n < 1000) begin
            @(negedge CLK);
            #1;
            n++;
        end
        while (!Begin_SUM && n < 1000) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk(n < 1000, "abort_reach_timeout", n, 1000);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk(outs == 24'd0, "abort_outputs", int'(outs), 0);
        flush();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        push_run(1, RUN_CYC);
        start_run();
        wait_done(1000, "run_after_abort_timeout");
        check_run_end("bsum_count_after_abort");

        // Stalled first adder op plus a start request while busy.
        dir_mode = 0;
        push_run(0, RUN_CYC + 50);
        stall_once = 1;
        start_run();
        n = 0;
        while (!Begin_SUM && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        @(negedge CLK);
        stall_once = 0;
        repeat (20) @(negedge CLK);
        Begin_FSM = 1'b1;
        @(negedge CLK);
        Begin_FSM = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        chk(bsum_cnt == 1, "stall_no_repulse", bsum_cnt, 1);
        chk(Begin_SUM == 1'b0 && BUSY == 1'b1, "stall_waiting", int'({Begin_SUM, BUSY}), 1);
        wait_done(1500, "run_stall_timeout");
        check_run_end("bsum_count_stall");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
